// File: rtl/byte_packer_pkg.sv
// Shared types and helpers for the byte packer: FSM state enum and enabled-byte count.
package byte_packer_pkg;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  // Number of enabled (mask bit clear) bytes among the low 'width' mask bits.
  function automatic int unsigned count_zeros(input logic [31:0] mask, input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width && !mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/byte_compactor.sv
// Combinational byte compactor: packs the enabled bytes of a sample contiguously,
// lowest-index enabled byte at [7:0], and reports how many were enabled.
module byte_compactor
  import byte_packer_pkg::*;
#(
  parameter int unsigned IN_BYTES = 4
) (
  input  logic [IN_BYTES*8-1:0]          d,
  input  logic [IN_BYTES-1:0]            mask,
  output logic [IN_BYTES*8-1:0]          bytes_out,
  output logic [$clog2(IN_BYTES+1)-1:0]  n_en
);

  localparam int unsigned NW = $clog2(IN_BYTES + 1);

  int unsigned pos;

  always_comb begin
    bytes_out = '0;
    pos       = 0;
    for (int unsigned i = 0; i < IN_BYTES; i++) begin
      if (!mask[i]) begin
        bytes_out[pos*8 +: 8] = d[i*8 +: 8];
        pos++;
      end
    end
    n_en = NW'(count_zeros(32'(mask), IN_BYTES));
  end

endmodule

// File: rtl/byte_packer.sv
// Byte packer: compacts enabled input bytes into a byte FIFO and emits OUT_BYTES-wide words.
// Define BYTE_PACKER_FLUSH_EN to enable the FLUSH state that zero-pads and emits a partial word.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 4,
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned CAP_BYTES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic                           cfg_stb_i,
  input  logic [IN_BYTES-1:0]            cfg_i,
  input  logic                           stb_i,
  input  logic [IN_BYTES*8-1:0]          d_i,
  input  logic                           flush_i,
  input  logic                           rdy_i,
  output logic                           stb_o,
  output logic [OUT_BYTES*8-1:0]         q_o,
  output logic                           ovf_o,
  output logic [$clog2(CAP_BYTES+1)-1:0] level_o
);

  localparam int unsigned LW  = $clog2(CAP_BYTES + 1);
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned NW  = $clog2(IN_BYTES + 1);

`ifdef BYTE_PACKER_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic [IN_BYTES-1:0] mask_q;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  state_e              state_q, state_d;
  logic [7:0]          buf_q [CAP_BYTES];
  logic [7:0]          buf_d [CAP_BYTES];

  logic [IN_BYTES*8-1:0] cbytes;
  logic [NW-1:0]         n_en;

  logic       run, pop, accept, drop;
  logic [LW:0] level_ext, pop_amt, level_after, level_sum;

  byte_compactor #(
    .IN_BYTES(IN_BYTES)
  ) u_compactor (
    .d        (d_i),
    .mask     (mask_q),
    .bytes_out(cbytes),
    .n_en     (n_en)
  );

  always_comb begin
    run   = (state_q == StRun);
    stb_o = (level_q >= LW'(OUT_BYTES)) || (!run && level_q != '0);
    // Bytes at or above the fill level are always zero, which gives the flush padding for free.
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      q_o[i*8 +: 8] = stb_o ? buf_q[i] : 8'h00;
    end

    pop         = stb_o && rdy_i;
    level_ext   = {1'b0, level_q};
    pop_amt     = (level_q >= LW'(OUT_BYTES)) ? LW1'(OUT_BYTES) : level_ext;
    level_after = pop ? (level_ext - pop_amt) : level_ext;
    level_sum   = level_after + LW1'(n_en);
    accept      = stb_i && run && (n_en != '0) && (level_sum <= LW1'(CAP_BYTES));
    drop        = stb_i && run && (n_en != '0) && !accept;
    level_d     = accept ? level_sum[LW-1:0] : level_after[LW-1:0];
    ovf_d       = cfg_stb_i ? 1'b0 : (ovf_q | drop);

    state_d = state_q;
    unique case (state_q)
      StRun:   if (FlushEn && flush_i && level_q != '0) state_d = StFlush;
      StFlush: if (level_q == '0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // A partial-word pop (flush) empties the FIFO; shifting by a full word yields zeros there too.
  always_comb begin
    for (int unsigned i = 0; i < CAP_BYTES; i++) begin
      if (!pop) begin
        buf_d[i] = buf_q[i];
      end else if (i + OUT_BYTES < CAP_BYTES) begin
        buf_d[i] = buf_q[i+OUT_BYTES];
      end else begin
        buf_d[i] = 8'h00;
      end
      for (int unsigned k = 0; k < IN_BYTES; k++) begin
        if (accept && NW'(k) < n_en && level_after + LW1'(k) == LW1'(i)) begin
          buf_d[i] = cbytes[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      mask_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= StRun;
      for (int unsigned i = 0; i < CAP_BYTES; i++) buf_q[i] <= 8'h00;
    end else begin
      if (cfg_stb_i) mask_q <= cfg_i;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      for (int unsigned i = 0; i < CAP_BYTES; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign ovf_o   = ovf_q;
  assign level_o = level_q;

endmodule

// File: doc/byte_packer.md
# byte_packer

Parametrised byte packer for the capture path. Compacts the enabled bytes of each input sample into a byte FIFO and emits full OUT_BYTES-wide words under a valid/ready handshake. Adds downstream backpressure, sticky overflow detection and an optional end-of-capture flush of partial words. Sits between the channel-group sampler and the sample memory/transmitter.

## Interface
- IN_BYTES, 4: input sample width in bytes.
- OUT_BYTES, 4: output word width in bytes.
- CAP_BYTES, 16: FIFO capacity in bytes; must be ≥ IN_BYTES+OUT_BYTES.
- clk_i  in  1  system clock; one clock domain.
- rst_in  in  1  reset; synchronous, active-low.
- cfg_stb_i  in  1  cfg_i valid; loads the mask.
- cfg_i  in  IN_BYTES  byte-disable mask; bit i set = input byte i dropped.
- stb_i  in  1  d_i valid this cycle.
- d_i  in  IN_BYTES*8  input sample; byte i = d_i[8i+7:8i].
- flush_i  in  1  request emission of the partial word (ignored unless BYTE_PACKER_FLUSH_EN).
- rdy_i  in  1  downstream ready.
- stb_o  out  1  q_o valid.
- q_o  out  OUT_BYTES*8  output word.
- ovf_o  out  1  sticky overflow flag.
- level_o  out  $clog2(CAP_BYTES+1)  current FIFO fill in bytes.

## Operation
- Reset: mask = 0 (all bytes enabled), level = 0, state RUN, ovf_o = 0, stb_o = 0, q_o = 0, level_o = 0.
- Ordering: within a sample, the lowest-index enabled byte is the earliest; the earliest byte of a word goes to q_o[7:0].
- n_en = number of zero bits in the mask. When stb_i=1 and n_en=0: no effect, no overflow.
- Pop: word transferred when stb_o & rdy_i; removes OUT_BYTES bytes.
- Push: stb_i accepted iff level − (pop ? OUT_BYTES : 0) + n_en ≤ CAP_BYTES. Otherwise the whole sample is dropped (never partially) and ovf_o is set.
- level_next = level − (pop ? OUT_BYTES : 0) + (accept ? n_en : 0). Arithmetic width is $clog2(CAP_BYTES+1); it must never wrap.
- ovf_o: set on drop; cleared only by cfg_stb_i or reset. If a drop and cfg_stb_i occur in the same cycle, ovf_o is cleared.
- cfg_stb_i: the new mask applies from the next cycle. A same-cycle stb_i uses the old mask. Buffered data is kept.
- stb_o = 1 iff level ≥ OUT_BYTES, or state FLUSH with level > 0. q_o = the OUT_BYTES oldest bytes; q_o = 0 when stb_o = 0.
- q_o and stb_o stay stable while stb_o & ~rdy_i. A same-cycle push does not alter the presented word.
- States (BYTE_PACKER_FLUSH_EN only):
  - RUN → FLUSH on flush_i when level > 0.
  - FLUSH: full words drain normally. When 0 < level < OUT_BYTES, the word is padded with 0x00 in its upper bytes and emitted. The pop empties the FIFO.
  - FLUSH → RUN when level = 0.
  - In FLUSH, stb_i is ignored, with no overflow. flush_i with level = 0 has no effect.

## Timing
- Input-to-output latency: stb_i at edge t → bytes counted in level_o and eligible on q_o/stb_o after edge t (visible in cycle t+1).
- Outputs derive from registers only. There is no combinational path from stb_i or d_i to stb_o or q_o. rdy_i affects only the next state.
- Throughput: one word per cycle while level ≥ OUT_BYTES and rdy_i = 1.
- Reset asserted mid-operation: all state and outputs take their reset values after the next edge, regardless of stb_o or rdy_i.

## Configuration
- BYTE_PACKER_FLUSH_EN defined: FLUSH state and zero-padding as above.
- BYTE_PACKER_FLUSH_EN undefined:
  - flush_i is ignored; the FSM stays in RUN.
  - A partial word remains buffered until enough bytes arrive.

## Structure
- byte_packer_pkg: the state enum (RUN, FLUSH) and a popcount function for n_en.
- Sub-module byte_compactor: combinational; maps d_i and the mask to a contiguous enabled-byte vector (earliest at [7:0]) plus n_en.

## Test plan
- IN=OUT=4, CAP=16, mask 0000, rdy_i=1, d_i=0x44332211 → next cycle stb_o=1, q_o=0x44332211, then level_o=0.
- Mask 1010, d_i=0x44332211 then 0x88776655 → q_o=0x77553311 after the second sample; level_o=0 after the pop.
- rdy_i=0, mask 0000, five samples → first four accepted (level_o=16), fifth dropped, ovf_o=1, q_o stable. Then rdy_i=1 → four words in order; cfg_stb_i clears ovf_o.
- level_o=16, rdy_i=1 and stb_i same cycle → sample accepted, ovf_o stays 0, level_o stays 16.
- FLUSH_EN, mask 1110, d_i=0x000000AB, then flush_i → stb_o=1, q_o=0x000000AB, level_o=0, back to RUN. Without the macro: stb_o stays 0, level_o=1.
- rst_in=0 while stb_o=1 and rdy_i=0 → next cycle stb_o=0, q_o=0, ovf_o=0, level_o=0, mask reset to 0000.
